// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among ALU, load and debug
// requesters, with a registered write stage and a busy scoreboard for RAW hazard lookup.
module regfile_wb_arbiter #(
    parameter int NUM_REGS = 10
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic [2:0]  req_valid,
    input  logic [14:0] req_rd,
    input  logic [95:0] req_data,
    output logic [2:0]  req_ready,
    input  logic        claim_valid,
    input  logic [4:0]  claim_rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        busy_rs1,
    output logic        busy_rs2,
    output logic        WE3,
    output logic [4:0]  A3,
    output logic [31:0] WD3,
    output logic        err_rd
);
    // Handshake: requester i transfers on a posedge where req_valid[i] && req_ready[i];
    // rd/data must stay stable while valid and not yet granted.
    localparam logic [5:0] MAX_RD = 6'(NUM_REGS);

    logic [1:0]  ptr;
    logic [1:0]  gidx;
    logic        xfer;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;
    logic        rd_ok;
    logic        rd_high;
    logic [31:0] busy;

    always_comb begin
        logic [2:0] cand;
        logic       found;
        req_ready = '0;
        gidx      = '0;
        found     = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cand = {1'b0, ptr} + 3'(k);
            if (cand >= 3'd3) cand = cand - 3'd3;
            if (!found && req_valid[cand[1:0]]) begin
                found             = 1'b1;
                gidx              = cand[1:0];
                req_ready[cand[1:0]] = 1'b1;
            end
        end
    end

    assign xfer = |req_ready;

    always_comb begin
        case (gidx)
            2'd1:    begin sel_rd = req_rd[9:5];   sel_data = req_data[63:32]; end
            2'd2:    begin sel_rd = req_rd[14:10]; sel_data = req_data[95:64]; end
            default: begin sel_rd = req_rd[4:0];   sel_data = req_data[31:0];  end
        endcase
    end

    assign rd_high = ({1'b0, sel_rd} > MAX_RD);
    assign rd_ok   = (sel_rd != 5'd0) && !rd_high;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            ptr    <= 2'd0;
            WE3    <= 1'b0;
            A3     <= '0;
            WD3    <= '0;
            err_rd <= 1'b0;
        end else begin
            WE3 <= xfer && rd_ok;
            if (xfer) begin
                ptr <= (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
                A3  <= sel_rd;
                WD3 <= sel_data;
                if (rd_high) err_rd <= 1'b1;
            end
        end
    end

    // Bits outside 1..NUM_REGS are never set, so lookups need no range guard.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (r <= NUM_REGS) begin
                    if (claim_valid && claim_rd == 5'(r))
                        busy[r] <= 1'b1;
                    else if (xfer && sel_rd == 5'(r))
                        busy[r] <= 1'b0;
                end
            end
        end
    end

    assign busy_rs1 = busy[rs1];
    assign busy_rs2 = busy[rs2];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;
    localparam int NUM_REGS = 10;

    logic        CLK;
    logic        reset_n;
    logic [2:0]  req_valid;
    logic [14:0] req_rd;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        claim_valid;
    logic [4:0]  claim_rd;
    logic [4:0]  rs1, rs2;
    logic        busy_rs1, busy_rs2;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        err_rd;

    regfile_wb_arbiter #(.NUM_REGS(NUM_REGS)) dut (
        .CLK(CLK), .reset_n(reset_n),
        .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
        .claim_valid(claim_valid), .claim_rd(claim_rd),
        .rs1(rs1), .rs2(rs2), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
        .WE3(WE3), .A3(A3), .WD3(WD3), .err_rd(err_rd)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // scoreboard state
    int n_checks = 0;
    int n_errors = 0;
    logic [36:0] exp_q[$];

    int          m_ptr;
    bit          m_busy[32];
    bit          m_err;
    bit          m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    logic [4:0]  m_rd[3];
    logic [31:0] m_data[3];
    bit          pend[3];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_grant();
        for (int k = 0; k < 3; k++) begin
            int i = (m_ptr + k) % 3;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic model_busy(input logic [4:0] r);
        return (r >= 1 && r <= NUM_REGS) ? m_busy[r] : 1'b0;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_err = 0; m_we = 0; m_a3 = '0; m_wd = '0;
        for (int r = 0; r < 32; r++) m_busy[r] = 0;
        for (int i = 0; i < 3; i++) pend[i] = 0;
        exp_q.delete();
    endtask

    // driver tasks
    task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] data);
        m_rd[i] = rd; m_data[i] = data;
        req_rd[5*i +: 5]    = rd;
        req_data[32*i +: 32] = data;
    endtask

    task automatic idle_inputs();
        req_valid = '0; claim_valid = 0; claim_rd = '0; rs1 = '0; rs2 = '0;
    endtask

    // One cycle starting just after a negedge with inputs already driven.
    task automatic step();
        int g;
        logic [2:0] exp_ready;
        #1;
        g = model_grant();
        exp_ready = (g < 0) ? 3'b000 : 3'(1 << g);
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("busy_rs1", 64'(busy_rs1), 64'(model_busy(rs1)));
        check("busy_rs2", 64'(busy_rs2), 64'(model_busy(rs2)));
        @(posedge CLK);
        if (g >= 0) begin
            m_ptr = (g + 1) % 3;
            m_a3  = m_rd[g];
            m_wd  = m_data[g];
            m_we  = (m_rd[g] >= 1 && m_rd[g] <= NUM_REGS);
            if (m_rd[g] > NUM_REGS) m_err = 1;
            if (m_we) exp_q.push_back({m_a3, m_wd});
            if (m_rd[g] >= 1 && m_rd[g] <= NUM_REGS) m_busy[m_rd[g]] = 0;
            pend[g] = 0;
        end else begin
            m_we = 0;
        end
        if (claim_valid && claim_rd >= 1 && claim_rd <= NUM_REGS) m_busy[claim_rd] = 1;
        #1;
        check("WE3", 64'(WE3), 64'(m_we));
        check("A3", 64'(A3), 64'(m_a3));
        check("WD3", 64'(WD3), 64'(m_wd));
        check("err_rd", 64'(err_rd), 64'(m_err));
        if (m_we && exp_q.size() > 0) check("write_q", 64'({A3, WD3}), 64'(exp_q.pop_front()));
        @(negedge CLK);
    endtask

    initial begin
        idle_inputs();
        req_rd = '0; req_data = '0;
        model_reset();

        // reset with random inputs
        reset_n = 0;
        for (int i = 0; i < 3; i++) set_req(i, 5'($urandom_range(1, 10)), $urandom);
        req_valid = 3'b111;
        claim_valid = 1; claim_rd = 5'd3; rs1 = 5'd3; rs2 = 5'd4;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_WE3", 64'(WE3), 64'd0);
        check("rst_A3", 64'(A3), 64'd0);
        check("rst_WD3", 64'(WD3), 64'd0);
        check("rst_ready", 64'(req_ready), 64'(3'b001));
        check("rst_busy", 64'(busy_rs1), 64'd0);
        check("rst_err", 64'(err_rd), 64'd0);
        idle_inputs();
        reset_n = 1;
        @(negedge CLK);

        // single write
        set_req(0, 5'd5, 32'hDEADBEEF); req_valid = 3'b001; step();
        check("single_A3", 64'(A3), 64'd5);
        check("single_WD3", 64'(WD3), 64'hDEADBEEF);
        req_valid = 3'b000; step();
        check("single_WE3_off", 64'(WE3), 64'd0);

        // round robin with all three held
        set_req(0, 5'd1, 32'h11); set_req(1, 5'd2, 32'h22); set_req(2, 5'd3, 32'h33);
        req_valid = 3'b111;
        repeat (6) step();
        req_valid = 3'b000;

        // scoreboard: claim, clear by write, then claim colliding with clear
        claim_valid = 1; claim_rd = 5'd7; step();
        claim_valid = 0; rs1 = 5'd7; step();
        set_req(1, 5'd7, 32'hA5A5_0007); req_valid = 3'b010; step();
        req_valid = 3'b000; step();
        check("sb_cleared", 64'(busy_rs1), 64'd0);
        claim_valid = 1; claim_rd = 5'd7; step();
        req_valid = 3'b010; step();
        req_valid = 3'b000; claim_valid = 0; step();
        check("sb_set_wins", 64'(busy_rs1), 64'd1);

        // boundaries: rd 0, rd 12, claim 0
        set_req(2, 5'd0, 32'h1234); req_valid = 3'b100; rs2 = 5'd0; step();
        set_req(2, 5'd12, 32'h5678); step();
        check("err_set", 64'(err_rd), 64'd1);
        req_valid = 3'b000; claim_valid = 1; claim_rd = 5'd0; step();
        claim_valid = 0; step();
        check("err_sticky", 64'(err_rd), 64'd1);

        // reset in the cycle WE3 is high
        set_req(0, 5'd4, 32'hCAFE_F00D); claim_valid = 1; claim_rd = 5'd9; rs1 = 5'd9;
        req_valid = 3'b001; step();
        req_valid = 3'b000; claim_valid = 0;
        #2 reset_n = 0;
        #1;
        check("mid_rst_WE3", 64'(WE3), 64'd0);
        check("mid_rst_busy", 64'(busy_rs1), 64'd0);
        req_valid = 3'b111;
        #1;
        check("mid_rst_ptr", 64'(req_ready), 64'(3'b001));
        model_reset();
        idle_inputs();
        @(negedge CLK);
        reset_n = 1;
        @(negedge CLK);

        // randomized traffic with held pending requests
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1;
                    set_req(i, 5'($urandom_range(0, 13)), $urandom);
                end
            end
            req_valid   = {pend[2], pend[1], pend[0]};
            claim_valid = ($urandom_range(0, 2) == 0);
            claim_rd    = 5'($urandom_range(0, 13));
            rs1         = 5'($urandom_range(0, 13));
            rs2         = 5'($urandom_range(0, 13));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port (WE3/A3/WD3) between three writeback requesters: ALU, load unit and debug port. Requesters use valid/ready handshakes and are served round-robin. Each grant is registered into a one-cycle write stage that drives the register file. An internal scoreboard tracks destination registers with outstanding writes, so decode can detect RAW hazards on rs1/rs2.

## Interface
Parameters:
- NUM_REGS, 10, highest implemented register index; valid write targets are 1..NUM_REGS.

Ports:
- CLK  input  1  single clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  3  per-requester write request; bit0 ALU, bit1 load, bit2 debug.
- req_rd  input  15  destination index, 5 bits per requester; requester i uses bits [5i+4:5i].
- req_data  input  96  write data, 32 bits per requester; requester i uses bits [32i+31:32i].
- req_ready  output  3  one-hot grant; combinational from req_valid and the round-robin pointer.
- claim_valid  input  1  decode reserves a destination register.
- claim_rd  input  5  register being reserved.
- rs1, rs2  input  5 each  source indices for hazard lookup.
- busy_rs1, busy_rs2  output  1 each  combinational scoreboard lookup; 0 for index 0.
- WE3  output  1  registered write enable to the register file.
- A3  output  5  registered write address.
- WD3  output  32  registered write data.
- err_rd  output  1  sticky; set when a granted write targets rd > NUM_REGS.

## Operation
- Arbitration:
  - 2-bit pointer ptr in {0,1,2} names the highest-priority requester.
  - The search order is ptr, ptr+1, ptr+2 (mod 3); the first asserted req_valid bit gets req_ready.
  - At most one req_ready bit is high; req_ready is 0 when no req_valid bit is set.
  - A transfer is req_valid[i] & req_ready[i] at posedge. After a transfer by i, ptr becomes (i+1) mod 3.
  - ptr is unchanged in cycles with no transfer.
  - A requester must hold rd/data stable while valid and unserved.
- Write stage, at each posedge:
  - With a transfer from i: A3 <= rd_i and WD3 <= data_i.
  - WE3 <= 1 only if 1 <= rd_i <= NUM_REGS; otherwise WE3 <= 0.
  - The request is still consumed (ready asserted) when rd_i is 0 or out of range.
  - If rd_i > NUM_REGS, err_rd <= 1.
  - With no transfer: WE3 <= 0, and A3/WD3 hold their previous values.
- Scoreboard, busy[1..NUM_REGS]:
  - Set: at posedge, when claim_valid is high and 1 <= claim_rd <= NUM_REGS.
  - Clear: at the posedge where a transfer with that rd is accepted, i.e. the same edge that loads the write stage.
  - Same register claimed and cleared on one edge: set wins (the new producer is outstanding).
  - Claims to 0 or to an index > NUM_REGS are ignored.
- busy_rsX = busy[rsX] for 1 <= rsX <= NUM_REGS, else 0.
- err_rd clears only on reset.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert) sets all of the following to 0: WE3, A3, WD3, ptr, busy[], err_rd. req_ready therefore follows from ptr=0.
- Latency: transfer at posedge N puts WE3/A3/WD3 valid for cycle N+1. The register file captures them at the negedge inside cycle N+1.
  - RD1/RD2 show the new value from that negedge onward.
  - busy drops at posedge N. Decode in cycle N+1 can read rs = rd, because the register file forwards nothing but the value lands by mid-cycle N+1.
- Throughput: one write per cycle. With back-to-back transfers WE3 stays high continuously, and A3/WD3 change every posedge.
- All three requesters valid and held: grants rotate 0,1,2,0,… starting from the current ptr.
  - No requester waits more than 2 cycles once it is valid.
- Reset mid-operation:
  - Any pending write-stage contents are discarded (WE3 forced 0 immediately).
  - Scoreboard clears. Requesters must re-present requests after reset.

## Test plan
- Reset check: hold reset_n=0 with random inputs -> WE3=0, A3=0, WD3=0, req_ready=3'b001 if req_valid=3'b111, busy_rs1=0, err_rd=0. Release reset.
- Single write: ALU valid, rd=5, data=0xDEADBEEF at posedge N -> WE3=1, A3=5, WD3=0xDEADBEEF in cycle N+1, WE3=0 in N+2, and RD1 for rs1=5 reads 0xDEADBEEF after the negedge of N+1.
- Round-robin: all three valid continuously with rd=1,2,3 -> grant order ALU, load, debug, ALU…, with WE3 high every cycle and A3 sequence 1,2,3,1.
- Scoreboard: claim rd=7, then next cycle busy_rs1 (rs1=7)=1. Load writes rd=7 -> busy_rs1=0 after accept edge. Simultaneous claim rd=7 with the accepting write to rd=7 -> busy stays 1.
- Boundaries:
  - Write rd=0 -> req_ready=1, WE3=0, no busy change.
  - Write rd=12 with NUM_REGS=10 -> WE3=0, err_rd=1 and sticky.
  - Claim rd=0 -> ignored.
- Reset mid-stream: assert reset_n=0 in the cycle WE3=1 -> WE3 drops without waiting for CLK, busy[] clears, ptr=0.
